// File: rtl/train_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// train_sequencer
//
// Walks an external sample ROM over NUM_CLASSES x SAMPLES_PER_CLASS training
// samples for up to NUM_EPOCHS epochs. Each sample goes to the network's learn
// port through a valid/ready handshake. Ordering is either class-major (sample
// loop inside the class loop) or interleaved (class loop inside the sample
// loop). The block counts mispredictions per epoch and can stop after the
// first error-free epoch.
//
// Ports
//   clk          single clock
//   rst          synchronous, active-high reset (all outputs return to 0)
//   start        level; a rising edge in IDLE/DONE launches a run
//   abort        level; returns a running sequencer to IDLE
//   pause        level; holds the sequencer in FETCH (no ROM read)
//   order_mode   0 = class-major, 1 = interleaved (latched at launch)
//   early_stop   1 = finish after the first zero-error epoch (latched at launch)
//   rom_en       ROM read strobe
//   rom_addr     class*SAMPLES_PER_CLASS + sample (meaningful while rom_en=1)
//   rom_data     ROM word, valid the cycle after rom_en
//   learn_valid  sample presented to the network
//   learn_ready  network accepts the sample
//   learn_x      sample data
//   learn_label  class index of the sample
//   nn_err       misprediction flag, sampled only on accept
//   busy         run in progress
//   done         run completed normally; held until the next launch
//   epoch        epochs completed in the current run
//   epoch_tick   one-cycle pulse at each epoch end
//   epoch_err    error count of the last completed epoch
// -----------------------------------------------------------------------------
module train_sequencer #(
  parameter int DATA_W            = 16,
  parameter int NUM_CLASSES       = 2,
  parameter int SAMPLES_PER_CLASS = 100,
  parameter int NUM_EPOCHS        = 10,
  parameter int HOLD_CYCLES       = 50,
  localparam int CLS_W  = ($clog2(NUM_CLASSES) > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int SMP_W  = ($clog2(SAMPLES_PER_CLASS) > 1) ? $clog2(SAMPLES_PER_CLASS) : 1,
  localparam int ADDR_W = ($clog2(NUM_CLASSES * SAMPLES_PER_CLASS) > 1) ?
                          $clog2(NUM_CLASSES * SAMPLES_PER_CLASS) : 1,
  localparam int EP_W   = $clog2(NUM_EPOCHS + 1),
  localparam int ERR_W  = $clog2(NUM_CLASSES * SAMPLES_PER_CLASS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic              order_mode,
  input  logic              early_stop,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              learn_valid,
  input  logic              learn_ready,
  output logic [DATA_W-1:0] learn_x,
  output logic [CLS_W-1:0]  learn_label,
  input  logic              nn_err,
  output logic              busy,
  output logic              done,
  output logic [EP_W-1:0]   epoch,
  output logic              epoch_tick,
  output logic [ERR_W-1:0]  epoch_err
);

  localparam int HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int GAP_W     = ($clog2(HOLD_CYCLES + 1) > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [CLS_W-1:0]  CLS_LAST  = CLS_W'(NUM_CLASSES - 1);
  localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(SAMPLES_PER_CLASS - 1);
  localparam logic [ADDR_W-1:0] SPC       = ADDR_W'(SAMPLES_PER_CLASS);
  localparam logic [EP_W-1:0]   EP_LAST   = EP_W'(NUM_EPOCHS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(HOLD_LAST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ROM_WAIT,
    S_PRESENT,
    S_GAP,
    S_EPOCH_END,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               start_d;
  logic               start_rise;
  logic               order_q;
  logic               early_q;
  logic [CLS_W-1:0]   cls_idx;
  logic [CLS_W-1:0]   cls_nxt;
  logic [SMP_W-1:0]   smp_idx;
  logic [SMP_W-1:0]   smp_nxt;
  logic [ERR_W-1:0]   err_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               idle_like;
  logic               launch;
  logic               accept;
  logic               cls_last;
  logic               smp_last;
  logic               last_sample;
  logic               idx_zero;
  logic               gap_done;
  logic               run_over;

  // Error counter increment that sticks at full scale instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == {ERR_W{1'b1}}) begin
      return v;
    end
    return v + ERR_W'(1);
  endfunction

  assign start_rise  = start & ~start_d;
  assign idle_like   = (state == S_IDLE) || (state == S_DONE);
  assign launch      = idle_like && start_rise && !abort;
  assign accept      = (state == S_PRESENT) && learn_ready && !abort;
  assign cls_last    = (cls_idx == CLS_LAST);
  assign smp_last    = (smp_idx == SMP_LAST);
  // Both orderings finish on (last class, last sample).
  assign last_sample = cls_last && smp_last;
  // After an accept the indices are back at (0,0) only when the epoch wrapped,
  // because there are always at least two samples per epoch.
  assign idx_zero    = (cls_idx == '0) && (smp_idx == '0);
  assign gap_done    = (gap_cnt == GAP_LAST);
  assign run_over    = (epoch == EP_LAST) || (early_q && (err_cnt == '0));

  // Next (class, sample) pair in the latched ordering.
  always_comb begin
    cls_nxt = cls_idx;
    smp_nxt = smp_idx;
    if (!order_q) begin
      if (smp_last) begin
        smp_nxt = '0;
        cls_nxt = cls_last ? '0 : cls_idx + CLS_W'(1);
      end else begin
        smp_nxt = smp_idx + SMP_W'(1);
      end
    end else begin
      if (cls_last) begin
        cls_nxt = '0;
        smp_nxt = smp_last ? '0 : smp_idx + SMP_W'(1);
      end else begin
        cls_nxt = cls_idx + CLS_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_rise) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (!pause) state_nxt = S_ROM_WAIT;
      end
      S_ROM_WAIT: begin
        state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        if (learn_ready) begin
          if (HOLD_CYCLES > 0) begin
            state_nxt = S_GAP;
          end else begin
            state_nxt = last_sample ? S_EPOCH_END : S_FETCH;
          end
        end
      end
      S_GAP: begin
        if (gap_done) state_nxt = idx_zero ? S_EPOCH_END : S_FETCH;
      end
      S_EPOCH_END: begin
        state_nxt = run_over ? S_DONE : S_FETCH;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Abort beats everything, including a simultaneous start edge; it leaves
    // IDLE/DONE where they are so done stays held.
    if (abort) state_nxt = idle_like ? state : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      start_d     <= 1'b0;
      order_q     <= 1'b0;
      early_q     <= 1'b0;
      cls_idx     <= '0;
      smp_idx     <= '0;
      err_cnt     <= '0;
      gap_cnt     <= '0;
      epoch       <= '0;
      epoch_err   <= '0;
      learn_x     <= '0;
      learn_label <= '0;
    end else begin
      state   <= state_nxt;
      start_d <= start;

      if (launch) begin
        order_q <= order_mode;
        early_q <= early_stop;
        cls_idx <= '0;
        smp_idx <= '0;
        err_cnt <= '0;
        epoch   <= '0;
      end

      // ROM word arrives one cycle after the read strobe.
      if (state == S_ROM_WAIT) begin
        learn_x     <= rom_data;
        learn_label <= cls_idx;
      end

      if (accept) begin
        if (nn_err) err_cnt <= sat_inc(err_cnt);
        cls_idx <= cls_nxt;
        smp_idx <= smp_nxt;
        gap_cnt <= '0;
      end

      if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);

      if ((state == S_EPOCH_END) && !abort) begin
        epoch_err <= err_cnt;
        err_cnt   <= '0;
        epoch     <= epoch + EP_W'(1);
      end
    end
  end

  assign rom_en      = (state == S_FETCH) && !pause;
  assign rom_addr    = ADDR_W'(cls_idx) * SPC + ADDR_W'(smp_idx);
  assign learn_valid = (state == S_PRESENT);
  assign busy        = !idle_like;
  assign done        = (state == S_DONE);
  assign epoch_tick  = (state == S_EPOCH_END) && !abort;

endmodule

// File: tb/tb_train_sequencer.sv
`timescale 1ns/1ps
module tb_train_sequencer;
  localparam int DATA_W = 16;
  localparam int NC     = 2;
  localparam int SPC    = 4;
  localparam int NE     = 3;
  localparam int HOLD   = 2;
  localparam int CLS_W  = 1;
  localparam int ADDR_W = 3;
  localparam int EP_W   = 2;
  localparam int ERR_W  = 4;

  logic              clk = 1'b0;
  logic              rst, start, abort, pause, order_mode, early_stop;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic              learn_valid, learn_ready;
  logic [DATA_W-1:0] learn_x;
  logic [CLS_W-1:0]  learn_label;
  logic              nn_err, busy, done, epoch_tick;
  logic [EP_W-1:0]   epoch;
  logic [ERR_W-1:0]  epoch_err;

  typedef struct {
    int addr;
    int gap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errs   = 0;
  int   cyc    = 0;
  int   acc_cnt = 0;
  int   tick_cnt = 0;
  int   last_acc_cyc = 0;
  int   last_tick_cyc = 0;
  int   cm_tbl[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int   il_tbl[8] = '{0, 4, 1, 5, 2, 6, 3, 7};
  logic [DATA_W-1:0] x0;
  logic [CLS_W-1:0]  l0;

  train_sequencer #(
    .DATA_W(DATA_W), .NUM_CLASSES(NC), .SAMPLES_PER_CLASS(SPC),
    .NUM_EPOCHS(NE), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .order_mode(order_mode), .early_stop(early_stop),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .learn_valid(learn_valid), .learn_ready(learn_ready),
    .learn_x(learn_x), .learn_label(learn_label), .nn_err(nn_err),
    .busy(busy), .done(done), .epoch(epoch), .epoch_tick(epoch_tick),
    .epoch_err(epoch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_pat(input int a);
    return 16'h1000 + 16'(a) * 16'h0111;
  endfunction

  // Synchronous sample ROM.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_pat(int'(rom_addr));
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (epoch_tick) begin
        tick_cnt++;
        last_tick_cyc = cyc;
      end
      if (learn_valid && learn_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_accept: got x=0x%0h label=%0d, required no accept", learn_x, learn_label);
        end else begin
          mon_e = sb.pop_front();
          chk("accept_x", 32'(learn_x), 32'(rom_pat(mon_e.addr)));
          chk("accept_label", 32'(learn_label), mon_e.addr / SPC);
          if (mon_e.gap != 0) chk("accept_spacing", cyc - last_acc_cyc, mon_e.gap);
        end
        acc_cnt++;
        last_acc_cyc = cyc;
      end
    end
  end

  task automatic push_run(input bit il, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.addr = il ? il_tbl[i % 8] : cm_tbl[i % 8];
      e.gap  = (i == 0) ? 0 : ((i % 8 == 0) ? 6 : 5);
      sb.push_back(e);
    end
  endtask

  task automatic push_one(input int addr, input int gap);
    exp_t e;
    e.addr = addr;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rom_en"}, 32'(rom_en), 0);
    chk({tag, "_learn_valid"}, 32'(learn_valid), 0);
    chk({tag, "_learn_x"}, 32'(learn_x), 0);
    chk({tag, "_learn_label"}, 32'(learn_label), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_epoch"}, 32'(epoch), 0);
    chk({tag, "_epoch_tick"}, 32'(epoch_tick), 0);
    chk({tag, "_epoch_err"}, 32'(epoch_err), 0);
  endtask

  // Called just after a rising edge; returns just after the edge where the
  // n-th accept took place.
  task automatic wait_acc(input int n);
    int b = 0;
    while (acc_cnt < n && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    if (acc_cnt < n) begin
      checks++;
      errs++;
      $display("FAIL wait_acc: got %0d accepts, required %0d", acc_cnt, n);
    end
  endtask

  task automatic wait_ticks(input int n);
    int b = 0;
    while (tick_cnt < n && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    if (tick_cnt < n) begin
      checks++;
      errs++;
      $display("FAIL wait_ticks: got %0d ticks, required %0d", tick_cnt, n);
    end
  endtask

  task automatic wait_done();
    int b = 0;
    while (!done && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    chk("done_reached", 32'(done), 1);
    chk("done_after_tick", cyc, last_tick_cyc + 1);
    chk("done_busy_low", 32'(busy), 0);
  endtask

  task automatic wait_valid_negedge();
    int b = 0;
    while (!learn_valid && b < 40) begin
      @(negedge clk);
      b++;
    end
    chk("present_reached", 32'(learn_valid), 1);
  endtask

  // Launch with a start edge and check the start+1..start+3 timeline. The mode
  // inputs are flipped right after launch to prove they were latched.
  task automatic start_run(input bit om, input bit es);
    acc_cnt  = 0;
    tick_cnt = 0;
    order_mode = om;
    early_stop = es;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    order_mode = ~om;
    early_stop = ~es;
    @(negedge clk);
    chk("fetch0_rom_en", 32'(rom_en), 1);
    chk("fetch0_addr", 32'(rom_addr), 0);
    chk("fetch0_busy_done", 32'({busy, done}), 32'b10);
    @(negedge clk);
    chk("romwait_quiet", 32'({rom_en, learn_valid}), 0);
    @(negedge clk);
    chk("first_valid", 32'(learn_valid), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    order_mode = 1'b0; early_stop = 1'b0; learn_ready = 1'b1; nn_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Class-major, three full epochs; a start pulse mid-run must be ignored.
    push_run(1'b0, 24);
    start_run(1'b0, 1'b0);
    wait_acc(10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("cm_ticks", tick_cnt, 3);
    chk("cm_epoch", 32'(epoch), 3);
    chk("cm_epoch_err", 32'(epoch_err), 0);
    chk("cm_sb_empty", sb.size(), 0);

    // Interleaved, restarted straight from DONE, ready held low 7 cycles in
    // the second PRESENT.
    push_run(1'b1, 24);
    sb[1].gap = 12;
    start_run(1'b1, 1'b0);
    wait_acc(1);
    learn_ready = 1'b0;
    wait_valid_negedge();
    x0 = learn_x;
    l0 = learn_label;
    repeat (6) begin
      @(negedge clk);
      chk("stall_hold", 32'({learn_valid, learn_x, learn_label}), 32'({1'b1, x0, l0}));
    end
    @(posedge clk); #1;
    learn_ready = 1'b1;
    wait_done();
    chk("il_ticks", tick_cnt, 3);
    chk("il_epoch", 32'(epoch), 3);
    chk("il_sb_empty", sb.size(), 0);

    // Early stop: three errors in epoch 0, none in epoch 1.
    nn_err = 1'b1;
    push_run(1'b0, 16);
    start_run(1'b0, 1'b1);
    wait_acc(3);
    nn_err = 1'b0;
    wait_ticks(1);
    chk("es_err_ep0", 32'(epoch_err), 3);
    chk("es_epoch_1", 32'(epoch), 1);
    wait_done();
    chk("es_err_ep1", 32'(epoch_err), 0);
    chk("es_epoch_2", 32'(epoch), 2);
    chk("es_ticks", tick_cnt, 2);
    chk("es_sb_empty", sb.size(), 0);

    // Abort together with a start edge while in DONE: nothing launches.
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_vs_start", 32'({busy, rom_en, done}), 32'b001);
    @(negedge clk);
    chk("abort_vs_start_hold", 32'({busy, rom_en, done}), 32'b001);
    @(posedge clk); #1;

    // Pause during the gap after the second sample, then abort mid-PRESENT.
    push_one(0, 0);
    push_one(1, 5);
    push_one(2, 0);
    start_run(1'b0, 1'b0);
    wait_acc(2);
    pause = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("pause_no_fetch", 32'(rom_en), 0);
    end
    @(posedge clk); #1;
    pause = 1'b0;
    @(negedge clk);
    chk("pause_release_fetch", 32'({rom_en, rom_addr}), 32'({1'b1, 3'd2}));
    @(posedge clk); #1;
    wait_acc(3);
    learn_ready = 1'b0;
    wait_valid_negedge();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_outputs", 32'({busy, learn_valid, done}), 0);
    chk("abort_epoch_kept", 32'(epoch), 0);
    abort = 1'b0;
    learn_ready = 1'b1;
    chk("abort_sb_empty", sb.size(), 0);
    @(posedge clk); #1;

    // One erroneous epoch, then reset mid-run and relaunch from address 0.
    nn_err = 1'b1;
    push_run(1'b0, 10);
    start_run(1'b0, 1'b0);
    wait_ticks(1);
    chk("rst_run_err", 32'(epoch_err), 8);
    chk("rst_run_epoch", 32'(epoch), 1);
    wait_acc(10);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("midrun");
    rst = 1'b0;
    nn_err = 1'b0;
    chk("rst_sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    push_one(0, 0);
    start_run(1'b0, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("final_abort_busy", 32'(busy), 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
